// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes, MDU op codes and MDU state type
package alu_pkg;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_OR   = 4'd2;
   localparam logic [3:0] ALU_LUI  = 4'd3;
   localparam logic [3:0] ALU_AND  = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SLT  = 4'd6;
   localparam logic [3:0] ALU_SLTU = 4'd7;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6,
      MD_RSVD  = 3'd7
   } md_op_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mdu_state_t;

endpackage

// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
// Divider present only when ALU_MDU_DIV_EN is defined.
module mdu_unit
   import alu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       md_op,
   input  logic             md_start,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             md_busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

`ifdef ALU_MDU_DIV_EN
   localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
`else
   localparam int CNT_MAX = MUL_CYCLES;
`endif
   localparam int CW = $clog2(CNT_MAX + 1);

   mdu_state_t       state, state_nxt;
   md_op_t           op, op_q;
   logic [CW-1:0]    cnt, cnt_load;
   logic [WIDTH-1:0] a_q, b_q, res_hi, res_lo;
   logic [2*WIDTH-1:0] a_ext, b_ext, prod;
   logic             is_mul, is_div, accept, done;

   assign op     = md_op_t'(md_op);
   assign is_mul = (op == MD_MULT) || (op == MD_MULTU);
`ifdef ALU_MDU_DIV_EN
   assign is_div   = (op == MD_DIV) || (op == MD_DIVU);
   assign cnt_load = is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
`else
   assign is_div   = 1'b0;
   assign cnt_load = CW'(MUL_CYCLES);
`endif
   assign accept = (state == IDLE) && md_start && (is_mul || is_div);
   assign done   = (state == BUSY) && (cnt == CW'(1));

   // Sign- or zero-extend to 2*WIDTH so one unsigned multiply covers both forms.
   always_comb begin
      a_ext = {{WIDTH{1'b0}}, a_q};
      b_ext = {{WIDTH{1'b0}}, b_q};
      if (op_q == MD_MULT) begin
         a_ext = {{WIDTH{a_q[WIDTH-1]}}, a_q};
         b_ext = {{WIDTH{b_q[WIDTH-1]}}, b_q};
      end
      prod = a_ext * b_ext;
   end

`ifdef ALU_MDU_DIV_EN
   logic [WIDTH-1:0] quo, rem;
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   always_comb begin
      quo = '1;
      rem = a_q;
      if (b_q != '0) begin
         if (op_q == MD_DIV) begin
            if (a_q == MOST_NEG && b_q == '1) begin
               quo = MOST_NEG;
               rem = '0;
            end else begin
               quo = WIDTH'($signed(a_q) / $signed(b_q));
               rem = WIDTH'($signed(a_q) % $signed(b_q));
            end
         end else begin
            quo = a_q / b_q;
            rem = a_q % b_q;
         end
      end
   end

   always_comb begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
      if (op_q == MD_DIV || op_q == MD_DIVU) begin
         res_hi = rem;
         res_lo = quo;
      end
   end
`else
   assign res_hi = prod[2*WIDTH-1:WIDTH];
   assign res_lo = prod[WIDTH-1:0];
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = BUSY;
         BUSY:    if (done)   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      md_busy = (state == BUSY);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt  <= '0;
         a_q  <= '0;
         b_q  <= '0;
         op_q <= MD_NONE;
         hi   <= '0;
         lo   <= '0;
      end else if (accept) begin
         cnt  <= cnt_load;
         a_q  <= src_a;
         b_q  <= src_b;
         op_q <= op;
      end else if (state == BUSY) begin
         if (done) begin
            cnt <= '0;
            hi  <= res_hi;
            lo  <= res_lo;
         end else begin
            cnt <= cnt - CW'(1);
         end
      end else if (md_start && op == MD_MTHI) begin
         hi <= src_a;
      end else if (md_start && op == MD_MTLO) begin
         lo <= src_a;
      end
   end

endmodule

// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - combinational ALU beside the multi-cycle MDU
// Divide support is compiled in with ALU_MDU_DIV_EN.
module alu_mdu
   import alu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic [3:0]       alu_ctrl,
   output logic [WIDTH-1:0] alu_result,
   output logic             alu_zero,
   output logic             alu_ovf,
   input  logic [2:0]       md_op,
   input  logic             md_start,
   output logic             md_busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [WIDTH-1:0] sum, diff;

   assign sum  = src_a + src_b;
   assign diff = src_a - src_b;

   always_comb begin
      alu_result = '0;
      alu_ovf    = 1'b0;
      case (alu_ctrl)
         ALU_ADD: begin
            alu_result = sum;
            alu_ovf    = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
         end
         ALU_SUB: begin
            alu_result = diff;
            alu_ovf    = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
         end
         ALU_OR:   alu_result = src_a | src_b;
         ALU_LUI:  alu_result = src_b << (WIDTH / 2);
         ALU_AND:  alu_result = src_a & src_b;
         ALU_XOR:  alu_result = src_a ^ src_b;
         ALU_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         ALU_SLTU: alu_result = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
         default:  alu_result = '0;
      endcase
   end

   assign alu_zero = (alu_result == '0);

   mdu_unit #(
      .WIDTH      (WIDTH),
      .MUL_CYCLES (MUL_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_mdu (
      .clk      (clk),
      .reset    (reset),
      .md_op    (md_op),
      .md_start (md_start),
      .src_a    (src_a),
      .src_b    (src_b),
      .md_busy  (md_busy),
      .hi       (hi),
      .lo       (lo)
   );

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter WIDTH, default 32: datapath width in bits; even, at least 8.
REQ-002 Parameter MUL_CYCLES, default 5: busy cycles for mult/multu; at least 1.
REQ-003 Parameter DIV_CYCLES, default 10: busy cycles for div/divu; at least 1.
REQ-004 The clock is clk, input, 1 bit, all state updates on its rising edge.
REQ-005 The reset is reset, input, 1 bit; it is asynchronous and active-high.
REQ-006 src_a, input, WIDTH: operand A.
REQ-007 src_b, input, WIDTH: operand B.
REQ-008 alu_ctrl, input, 4: ALU operation select.
REQ-009 alu_result, output, WIDTH: combinational ALU result.
REQ-010 alu_zero, output, 1: alu_result equals zero.
REQ-011 alu_ovf, output, 1: signed overflow on ADD or SUB.
REQ-012 md_op, input, 3: MDU operation; 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-013 md_start, input, 1: single-cycle MDU request qualifier.
REQ-014 md_busy, output, 1: MDU operation in flight.
REQ-015 hi, output, WIDTH: HI register.
REQ-016 lo, output, WIDTH: LO register.

Function
REQ-017 The ALU SHALL implement the following alu_ctrl encodings: 0 ADD, 1 SUB, 2 OR, 3 LUI (src_b shifted left by WIDTH/2, zero filled), 4 AND, 5 XOR, 6 SLT (signed, result 1 or 0), 7 SLTU; codes 8-15 SHALL give result 0.
REQ-018 ADD and SUB SHALL wrap modulo 2^WIDTH; alu_ovf SHALL be asserted only for ADD or SUB with signed overflow, and deasserted for all other codes.
REQ-019 alu_zero SHALL be asserted for any code whose alu_result is 0; the ALU path has no state and zero latency.
REQ-020 The MDU FSM SHALL have exactly two states, IDLE and BUSY.
REQ-021 In IDLE, md_start with md_op mult/multu/div/divu SHALL latch operands, load the counter with the op latency, and enter BUSY on that edge.
REQ-022 md_busy SHALL equal (state == BUSY) and remain high for exactly MUL_CYCLES or DIV_CYCLES cycles.
REQ-023 hi and lo SHALL update on the edge that returns the FSM to IDLE, so that new values are visible in the first cycle with md_busy low.
REQ-024 mult/multu SHALL place the 2*WIDTH product, signed or unsigned respectively, with the upper half in hi and the lower half in lo.
REQ-025 div/divu SHALL place the quotient in lo and the remainder in hi; the quotient truncates toward zero and the remainder takes the sign of the dividend.
REQ-026 Division by zero SHALL give lo = all ones and hi = dividend.
REQ-027 Signed division of the most negative value by -1 SHALL give lo = the most negative value and hi = 0.
REQ-028 mthi/mtlo with md_start in IDLE SHALL write src_a to hi or lo on the next edge with no busy cycle.
REQ-029 md_start SHALL be ignored while BUSY, with no queuing and no effect on the operation in flight.
REQ-030 md_start with md_op none or reserved SHALL have no effect.
REQ-031 Operand changes after the latch edge SHALL NOT affect the result.

Reset
REQ-032 Reset SHALL immediately force the FSM to IDLE, the counter to 0, md_busy to 0, and hi and lo to 0.
REQ-033 Reset asserted during BUSY SHALL abort the operation, and no hi/lo write SHALL occur afterwards.

Configuration
REQ-034 The macro is ALU_MDU_DIV_EN; when it is defined, div/divu SHALL behave as in REQ-021 to REQ-027.
REQ-035 When ALU_MDU_DIV_EN is undefined, div/divu SHALL be treated as md_op none, leaving busy low and hi/lo unchanged; no divider logic SHALL be synthesised, and DIV_CYCLES SHALL be unused.

Structure
REQ-036 Package alu_pkg SHALL hold the alu_ctrl encodings, the md_op encodings and the MDU state type.
REQ-037 Sub-module mdu_unit SHALL contain the FSM, the counter, the operand latches and hi/lo; alu_mdu SHALL instantiate it beside the combinational ALU.

Verification
REQ-038 ALU: src_a=0x7FFFFFFF, src_b=1, ADD -> alu_result=0x80000000, alu_ovf=1, alu_zero=0; then SUB with src_a=src_b=5 -> alu_result=0, alu_zero=1.
REQ-039 LUI with src_b=0x1234 -> alu_result=0x12340000; SLT with src_a=-1, src_b=1 -> 1; SLTU with the same operands -> 0.
REQ-040 mult with src_a=-2, src_b=3 -> md_busy high for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; a md_start pulse mid-busy leaves the result and the busy length unchanged.
REQ-041 div with src_a=-7, src_b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu with src_b=0 and src_a=9 -> lo=0xFFFFFFFF, hi=9.
REQ-042 mthi with src_a=0xA5 -> hi=0xA5 on the next edge and md_busy never asserted; reset at busy cycle 3 of a mult -> md_busy=0, hi=lo=0, and no later write.
REQ-043 Build with ALU_MDU_DIV_EN undefined: a div request -> md_busy stays 0 and hi/lo are unchanged.
